// File: rtl/sdram_client_arbiter.sv
// Round-robin arbiter placing N concurrent clients onto a single SDRAMBus port, one transaction in flight,
// with optional single-owner lock and a watchdog that aborts transactions the SDRAM never completes.
module sdram_client_arbiter #(
    parameter int NUM_CLIENTS = 5,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 1024,
    localparam int IDW        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CLIENTS-1:0]        cli_read,
    input  logic [NUM_CLIENTS-1:0]        cli_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_writedata,
    output logic [DATA_W-1:0]             cli_readdata,
    output logic [NUM_CLIENTS-1:0]        cli_finished,
    output logic                          cli_error,
    input  logic                          lock_en,
    input  logic [IDW-1:0]                lock_id,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic                          sdram_read,
    output logic                          sdram_write,
    output logic [ADDR_W-1:0]             sdram_addr,
    output logic [DATA_W-1:0]             sdram_writedata,
    input  logic [DATA_W-1:0]             sdram_readdata,
    input  logic                          sdram_finished
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDW-1:0]           r_rr;
    logic [IDW-1:0]           r_grant_id;
    logic [WDW-1:0]           r_wdog;
    logic                     r_op_read;
    logic                     r_timed_out;
    logic                     r_sd_read;
    logic                     r_sd_write;
    logic [ADDR_W-1:0]        r_sd_addr;
    logic [DATA_W-1:0]        r_sd_wdata;
    logic [DATA_W-1:0]        r_readdata;
    logic [NUM_CLIENTS-1:0]   r_cli_finished;
    logic                     r_cli_error;
    logic                     r_busy;

    logic [NUM_CLIENTS-1:0]   w_lock_mask;
    logic [NUM_CLIENTS-1:0]   w_elig;
    logic                     w_found;
    logic [IDW-1:0]           w_pick;
    logic                     w_timeout;

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            v[k] = (int'(idx) == k);
        end
        return v;
    endfunction

    // Eligibility mask: an out-of-range lock_id matches no client, so nothing is granted.
    always_comb begin
        w_lock_mask = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_lock_mask[k] = !lock_en || (int'(lock_id) == k);
        end
    end

    assign w_elig    = (cli_read | cli_write) & w_lock_mask;
    assign w_timeout = (r_wdog == WDW'(TIMEOUT - 1));

    // Round-robin search starting just after the last granted client, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            int idx;
            idx     = (int'(r_rr) + i) % NUM_CLIENTS;
            w_pick  = (!w_found && w_elig[idx]) ? IDW'(idx) : w_pick;
            w_found = w_found | w_elig[idx];
        end
    end

    // Next-state logic for the IDLE -> BUSY -> ACK -> GAP cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (sdram_finished || w_timeout) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_ACK:  w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs; a reset mid-transaction drops it without a completion pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr           <= IDW'(NUM_CLIENTS - 1);
            r_grant_id     <= '0;
            r_wdog         <= '0;
            r_op_read      <= 1'b0;
            r_timed_out    <= 1'b0;
            r_sd_read      <= 1'b0;
            r_sd_write     <= 1'b0;
            r_sd_addr      <= '0;
            r_sd_wdata     <= '0;
            r_readdata     <= '0;
            r_cli_finished <= '0;
            r_cli_error    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_cli_finished <= '0;
            r_cli_error    <= 1'b0;
            r_busy         <= (w_state_nxt == ST_BUSY) || (w_state_nxt == ST_ACK);
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_rr        <= w_pick;
                        r_wdog      <= '0;
                        r_timed_out <= 1'b0;
                        r_op_read   <= cli_read[w_pick] && !cli_write[w_pick];
                        r_sd_read   <= cli_read[w_pick] && !cli_write[w_pick];
                        r_sd_write  <= cli_write[w_pick];
                        r_sd_addr   <= cli_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                        r_sd_wdata  <= cli_writedata[int'(w_pick)*DATA_W +: DATA_W];
                    end
                end
                ST_BUSY: begin
                    if (sdram_finished) begin
                        r_sd_read  <= 1'b0;
                        r_sd_write <= 1'b0;
                        if (r_op_read) begin
                            r_readdata <= sdram_readdata;
                        end
                    end else if (w_timeout) begin
                        r_sd_read   <= 1'b0;
                        r_sd_write  <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                ST_ACK: begin
                    r_cli_finished <= onehot(r_grant_id);
                    r_cli_error    <= r_timed_out;
                    r_timed_out    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign cli_readdata    = r_readdata;
    assign cli_finished    = r_cli_finished;
    assign cli_error       = r_cli_error;
    assign grant_id        = r_grant_id;
    assign busy            = r_busy;
    assign sdram_read      = r_sd_read;
    assign sdram_write     = r_sd_write;
    assign sdram_addr      = r_sd_addr;
    assign sdram_writedata = r_sd_wdata;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter: reset, single read, round-robin, lock, watchdog timeout, read+write priority.
module tb_sdram_client_arbiter;

    localparam int N   = 5;
    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int IDW = 3;

    logic            i_clk;
    logic            i_rst;
    logic [N-1:0]    cli_read;
    logic [N-1:0]    cli_write;
    logic [N*AW-1:0] cli_addr;
    logic [N*DW-1:0] cli_writedata;
    logic [DW-1:0]   cli_readdata;
    logic [N-1:0]    cli_finished;
    logic            cli_error;
    logic            lock_en;
    logic [IDW-1:0]  lock_id;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            sdram_read;
    logic            sdram_write;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_writedata;
    logic [DW-1:0]   sdram_readdata;
    logic            sdram_finished;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_rdata;

    sdram_client_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cli_read(cli_read), .cli_write(cli_write),
        .cli_addr(cli_addr), .cli_writedata(cli_writedata),
        .cli_readdata(cli_readdata), .cli_finished(cli_finished), .cli_error(cli_error),
        .lock_en(lock_en), .lock_id(lock_id), .grant_id(grant_id), .busy(busy),
        .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
        .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst          = 1'b0;
        cli_read       = '0;
        cli_write      = '0;
        sdram_finished = 1'b0;
        lock_en        = 1'b0;
        lock_id        = '0;
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!(sdram_read || sdram_write) && n < 50) begin
            tick();
            n++;
        end
        n_total++;
        if (sdram_read || sdram_write) n_pass++;
        else $display("FAIL wait_grant: no sdram_read/write after %0d cycles, expected a grant", n);
    endtask

    // Called in grant cycle 1; pulses sdram_finished in cycle lat, returns in the cycle cli_finished shows.
    task automatic serve(input int lat, input logic [DW-1:0] data);
        for (int i = 1; i < lat; i++) tick();
        sdram_finished = 1'b1;
        sdram_readdata = data;
        tick();
        sdram_finished = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [N-1:0] acc;
        do_reset();
        n_total++;
        if ({cli_readdata, cli_finished, cli_error, grant_id, busy, sdram_read, sdram_write,
             sdram_addr, sdram_writedata} !== '0)
            $display("FAIL reset_outputs: some output nonzero, got rd=%h fin=%b gid=%0d busy=%b",
                     cli_readdata, cli_finished, grant_id, busy);
        else n_pass++;
        cli_addr[1*AW +: AW] = 23'h000055;
        cli_read[1] = 1'b1;
        wait_grant();
        n_total++;
        if (grant_id !== 3'd1) $display("FAIL reset_pre_grant: got %0d expected 1", grant_id);
        else n_pass++;
        tick();
        i_rst    = 1'b0;
        cli_read = '0;
        #1;
        n_total++;
        if ({sdram_read, busy, grant_id, sdram_addr} !== '0)
            $display("FAIL reset_mid_busy: rd=%b busy=%b gid=%0d addr=%h expected all 0",
                     sdram_read, busy, grant_id, sdram_addr);
        else n_pass++;
        tick();
        tick();
        i_rst = 1'b1;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | cli_finished;
        end
        n_total++;
        if (acc !== 5'b00000) $display("FAIL reset_no_finish: cli_finished seen %b expected 00000", acc);
        else n_pass++;
        cli_addr[0*AW +: AW] = 23'h000AAA;
        cli_addr[3*AW +: AW] = 23'h003333;
        cli_read[0] = 1'b1;
        cli_read[3] = 1'b1;
        wait_grant();
        n_total++;
        if (grant_id !== 3'd0 || sdram_addr !== 23'h000AAA)
            $display("FAIL reset_tie: grant %0d addr %h expected 0 / 000aaa", grant_id, sdram_addr);
        else n_pass++;
        serve(1, 32'h11111111);
        exp_rdata = 32'h11111111;
        n_total++;
        if (cli_finished !== 5'b00001) $display("FAIL reset_tie_fin: got %b expected 00001", cli_finished);
        else n_pass++;
        cli_read = '0;
    endtask

    task automatic test_single_read();
        int cnt;
        tick();
        cli_addr[2*AW +: AW] = 23'h001234;
        cli_read[2] = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (sdram_read === 1'b1) cnt++;
            if (c == 1) begin
                n_total++;
                if (grant_id !== 3'd2 || sdram_addr !== 23'h001234)
                    $display("FAIL single_grant: grant %0d addr %h expected 2 / 001234", grant_id, sdram_addr);
                else n_pass++;
            end
        end
        sdram_finished = 1'b1;
        sdram_readdata = 32'hDEADBEEF;
        tick();
        sdram_finished = 1'b0;
        n_total++;
        if (cnt !== 5 || sdram_read !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_read_window: high %0d cycles, rd=%b busy=%b expected 5/0/1", cnt, sdram_read, busy);
        else n_pass++;
        tick();
        n_total++;
        if (cli_finished !== 5'b00100 || cli_readdata !== 32'hDEADBEEF || cli_error !== 1'b0)
            $display("FAIL single_finish: fin=%b data=%h err=%b expected 00100/deadbeef/0",
                     cli_finished, cli_readdata, cli_error);
        else n_pass++;
        exp_rdata = 32'hDEADBEEF;
        cli_read = '0;
        tick();
        n_total++;
        if (cli_finished !== 5'b00000 || busy !== 1'b0)
            $display("FAIL single_pulse_len: fin=%b busy=%b expected 00000/0", cli_finished, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 4, 0};
        int e;
        do_reset();
        for (int k = 0; k < N; k++) begin
            cli_addr[k*AW +: AW]      = AW'(23'h000100 + k);
            cli_writedata[k*DW +: DW] = DW'(32'hC0DE0000 + k);
        end
        cli_write = 5'b10011;
        for (int j = 0; j < 4; j++) begin
            e = order[j];
            wait_grant();
            n_total++;
            if (int'(grant_id) != e) $display("FAIL rr_grant%0d: got %0d expected %0d", j, grant_id, e);
            else n_pass++;
            n_total++;
            if (sdram_write !== 1'b1 || sdram_addr !== AW'(23'h000100 + e) || sdram_writedata !== DW'(32'hC0DE0000 + e))
                $display("FAIL rr_bus%0d: wr=%b addr=%h data=%h expected client %0d pair", j, sdram_write,
                         sdram_addr, sdram_writedata, e);
            else n_pass++;
            tick();
            n_total++;
            if (sdram_addr !== AW'(23'h000100 + e)) $display("FAIL rr_stable%0d: addr %h moved", j, sdram_addr);
            else n_pass++;
            serve(1, 32'h0);
            n_total++;
            if (cli_finished !== (5'b00001 << e))
                $display("FAIL rr_fin%0d: got %b expected client %0d", j, cli_finished, e);
            else n_pass++;
        end
        cli_write = '0;
    endtask

    task automatic test_lock();
        logic act;
        lock_en = 1'b1;
        lock_id = 3'd3;
        cli_addr[1*AW +: AW] = 23'h000111;
        cli_addr[3*AW +: AW] = 23'h000333;
        cli_read = 5'b01010;
        for (int j = 0; j < 3; j++) begin
            wait_grant();
            n_total++;
            if (grant_id !== 3'd3 || sdram_addr !== 23'h000333)
                $display("FAIL lock_grant%0d: grant %0d addr %h expected 3 / 000333", j, grant_id, sdram_addr);
            else n_pass++;
            serve(2, DW'(32'h33330000 + j));
            exp_rdata = DW'(32'h33330000 + j);
            n_total++;
            if (cli_finished !== 5'b01000 || cli_readdata !== exp_rdata)
                $display("FAIL lock_fin%0d: fin=%b data=%h expected 01000/%h", j, cli_finished, cli_readdata, exp_rdata);
            else n_pass++;
        end
        lock_id = 3'd7;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            act = act | sdram_read | sdram_write | busy;
        end
        n_total++;
        if (act !== 1'b0) $display("FAIL lock_none: activity %b expected 0 with lock_id=7", act);
        else n_pass++;
        cli_read = '0;
        lock_en  = 1'b0;
        lock_id  = '0;
    endtask

    task automatic test_timeout();
        int cnt;
        cli_addr[4*AW +: AW] = 23'h004444;
        cli_read[4] = 1'b1;
        wait_grant();
        cnt = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sdram_read !== 1'b1) break;
            cnt++;
        end
        n_total++;
        if (cnt !== 8) $display("FAIL timeout_len: sdram_read high %0d cycles expected 8", cnt);
        else n_pass++;
        tick();
        n_total++;
        if (cli_finished !== 5'b10000 || cli_error !== 1'b1)
            $display("FAIL timeout_pulse: fin=%b err=%b expected 10000/1", cli_finished, cli_error);
        else n_pass++;
        n_total++;
        if (cli_readdata !== exp_rdata) $display("FAIL timeout_data: got %h expected %h", cli_readdata, exp_rdata);
        else n_pass++;
        cli_read = '0;
        tick();
        n_total++;
        if (cli_error !== 1'b0 || cli_finished !== 5'b00000)
            $display("FAIL timeout_pulse_len: err=%b fin=%b expected 0/00000", cli_error, cli_finished);
        else n_pass++;
    endtask

    task automatic test_rw_both();
        cli_writedata[0*DW +: DW] = 32'hA5A5A5A5;
        cli_addr[0*AW +: AW]      = 23'h000777;
        cli_read[0]  = 1'b1;
        cli_write[0] = 1'b1;
        wait_grant();
        n_total++;
        if (sdram_write !== 1'b1 || sdram_read !== 1'b0 || sdram_writedata !== 32'hA5A5A5A5)
            $display("FAIL rw_both: wr=%b rd=%b data=%h expected 1/0/a5a5a5a5", sdram_write, sdram_read, sdram_writedata);
        else n_pass++;
        serve(3, 32'hFFFF0000);
        n_total++;
        if (cli_finished !== 5'b00001 || cli_readdata !== exp_rdata)
            $display("FAIL rw_fin: fin=%b data=%h expected 00001/%h", cli_finished, cli_readdata, exp_rdata);
        else n_pass++;
        cli_read  = '0;
        cli_write = '0;
    endtask

    initial begin
        i_rst          = 1'b0;
        cli_read       = '0;
        cli_write      = '0;
        cli_addr       = '0;
        cli_writedata  = '0;
        lock_en        = 1'b0;
        lock_id        = '0;
        sdram_readdata = '0;
        sdram_finished = 1'b0;
        exp_rdata      = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_rw_both();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
